// File: rtl/risc16_pkg.sv
// RiSC-16 control package: opcodes, FSM states and
// datapath control encodings shared by the control unit.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [1:0] TGT_MEM = 2'b00;
  localparam logic [1:0] TGT_ALU = 2'b01;
  localparam logic [1:0] TGT_PC1 = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  typedef struct packed {
    logic       mux_rf;
    logic       mux_alu1;
    logic       mux_alu2;
    logic [1:0] func_alu;
    logic [1:0] mux_tgt;
    logic       wr_rf;
    logic       is_mem;
    logic       is_sw;
    logic       is_beq;
    logic       is_jalr;
    logic       jalr_halt;
  } ctrl_t;

endpackage

// File: rtl/risc16_ctrl_decode.sv
// Opcode to control-vector decode for the RiSC-16
// multi-cycle control unit.
module risc16_ctrl_decode
  import risc16_pkg::*;
#(
  parameter bit HALT_ON_JALR_IMM = 1'b1
) (
  input  logic [2:0] op,
  input  logic [6:0] imm7,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (op == OP_ADD): begin
        ctrl.func_alu = ALU_ADD;
        ctrl.mux_tgt  = TGT_ALU;
        ctrl.wr_rf    = 1'b1;
      end
      (op == OP_ADDI): begin
        ctrl.mux_alu2 = 1'b1;
        ctrl.func_alu = ALU_ADD;
        ctrl.mux_tgt  = TGT_ALU;
        ctrl.wr_rf    = 1'b1;
      end
      (op == OP_NAND): begin
        ctrl.func_alu = ALU_NAND;
        ctrl.mux_tgt  = TGT_ALU;
        ctrl.wr_rf    = 1'b1;
      end
      (op == OP_LUI): begin
        ctrl.mux_alu1 = 1'b1;
        ctrl.func_alu = ALU_PASS;
        ctrl.mux_tgt  = TGT_ALU;
        ctrl.wr_rf    = 1'b1;
      end
      (op == OP_SW): begin
        ctrl.mux_rf   = 1'b1;
        ctrl.mux_alu2 = 1'b1;
        ctrl.func_alu = ALU_ADD;
        ctrl.is_mem   = 1'b1;
        ctrl.is_sw    = 1'b1;
      end
      (op == OP_LW): begin
        ctrl.mux_alu2 = 1'b1;
        ctrl.func_alu = ALU_ADD;
        ctrl.mux_tgt  = TGT_MEM;
        ctrl.is_mem   = 1'b1;
      end
      (op == OP_BEQ): begin
        ctrl.mux_rf = 1'b1;
        ctrl.is_beq = 1'b1;
      end
      (op == OP_JALR): begin
        ctrl.mux_tgt   = TGT_PC1;
        ctrl.wr_rf     = 1'b1;
        ctrl.is_jalr   = 1'b1;
        ctrl.jalr_halt = HALT_ON_JALR_IMM && (imm7 != 7'd0);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/risc16_control_fsm.sv
// RiSC-16 multi-cycle control unit: fetch/decode/exec/mem
// sequencing with a req/ready memory port and watchdog.
module risc16_control_fsm
  import risc16_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT      = 0,
  parameter bit          HALT_ON_JALR_IMM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        alu_eq,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        MUX_addr,
  output logic        WE_ir,
  output logic        WE_pc,
  output logic [1:0]  MUX_pc,
  output logic        MUX_rf,
  output logic [1:0]  MUX_tgt,
  output logic        WE_rf,
  output logic [1:0]  FUNC_alu,
  output logic        MUX_alu1,
  output logic        MUX_alu2,
  output logic        halted,
  output logic        bus_error
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_n;
  ctrl_t         ctrl;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          wd_clr;
  logic          err_set;
  logic          unused_bits;

  assign unused_bits = ^instr[12:7];

  risc16_ctrl_decode #(
    .HALT_ON_JALR_IMM(HALT_ON_JALR_IMM)
  ) u_dec (
    .op  (instr[15:13]),
    .imm7(instr[6:0]),
    .ctrl(ctrl)
  );

  assign wd_hit = (MEM_TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign wd_clr = (state_n != state) &&
                  (state_n == S_FETCH || state_n == S_MEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wd_cnt    <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= state_n;
      if (err_set)
        bus_error <= 1'b1;
      if (wd_clr)
        wd_cnt <= '0;
      else if (mem_req && !mem_ready)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Everything is gated by rst_n so strobes drop the
  // instant reset asserts, even mid-access.
  always_comb begin
    state_n  = state;
    err_set  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    MUX_addr = 1'b0;
    WE_ir    = 1'b0;
    WE_pc    = 1'b0;
    MUX_pc   = PC_INC;
    MUX_rf   = 1'b0;
    MUX_tgt  = TGT_MEM;
    WE_rf    = 1'b0;
    FUNC_alu = ALU_ADD;
    MUX_alu1 = 1'b0;
    MUX_alu2 = 1'b0;
    halted   = 1'b0;
    if (rst_n) begin
      if (state inside {S_DECODE, S_EXEC, S_MEM}) begin
        MUX_rf   = ctrl.mux_rf;
        MUX_alu1 = ctrl.mux_alu1;
        MUX_alu2 = ctrl.mux_alu2;
        FUNC_alu = ctrl.func_alu;
      end
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            WE_ir   = 1'b1;
            state_n = S_DECODE;
          end else if (wd_hit) begin
            err_set = 1'b1;
            state_n = S_HALT;
          end
        end
        S_DECODE: begin
          state_n = ctrl.jalr_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (ctrl.is_mem) begin
            state_n = S_MEM;
          end else begin
            WE_rf   = ctrl.wr_rf;
            MUX_tgt = ctrl.mux_tgt;
            WE_pc   = 1'b1;
            if (ctrl.is_jalr)
              MUX_pc = PC_REG;
            else if (ctrl.is_beq && alu_eq)
              MUX_pc = PC_BR;
            else
              MUX_pc = PC_INC;
            state_n = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          MUX_addr = 1'b1;
          mem_we   = ctrl.is_sw;
          if (mem_ready) begin
            WE_pc   = 1'b1;
            MUX_pc  = PC_INC;
            WE_rf   = !ctrl.is_sw;
            MUX_tgt = TGT_MEM;
            state_n = S_FETCH;
          end else if (wd_hit) begin
            err_set = 1'b1;
            state_n = S_HALT;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Self-checking bench for risc16_control_fsm: instructions are
// expanded into expected per-cycle control steps and compared.
module tb_risc16_control_fsm;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        alu_eq = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, MUX_addr, WE_ir, WE_pc;
  logic [1:0]  MUX_pc, MUX_tgt, FUNC_alu;
  logic        MUX_rf, WE_rf, MUX_alu1, MUX_alu2;
  logic        halted, bus_error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mux_addr;
    logic       we_ir;
    logic       we_pc;
    logic [1:0] mux_pc;
    logic       mux_rf;
    logic [1:0] mux_tgt;
    logic       we_rf;
    logic [1:0] func_alu;
    logic       mux_alu1;
    logic       mux_alu2;
    logic       halted;
    logic       bus_error;
  } obs_t;

  typedef struct packed {
    logic [15:0] ins;
    logic        rdy;
    logic        eq;
    obs_t        e;
    obs_t        m;
  } step_t;

  obs_t  act;
  step_t sq[$];

  assign act = {mem_req, mem_we, MUX_addr, WE_ir, WE_pc,
                MUX_pc, MUX_rf, MUX_tgt, WE_rf, FUNC_alu,
                MUX_alu1, MUX_alu2, halted, bus_error};

  risc16_control_fsm #(
    .MEM_TIMEOUT(TO),
    .HALT_ON_JALR_IMM(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .alu_eq(alu_eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .MUX_addr(MUX_addr),
    .WE_ir(WE_ir), .WE_pc(WE_pc), .MUX_pc(MUX_pc),
    .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt), .WE_rf(WE_rf),
    .FUNC_alu(FUNC_alu), .MUX_alu1(MUX_alu1),
    .MUX_alu2(MUX_alu2), .halted(halted),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  function automatic obs_t bmask();
    obs_t m;
    m = '0;
    m.mem_req = 1'b1;
    m.we_ir = 1'b1;
    m.we_pc = 1'b1;
    m.we_rf = 1'b1;
    m.halted = 1'b1;
    m.bus_error = 1'b1;
    return m;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [15:0] ins, input logic rdy,
                      input logic eq, input obs_t e, input obs_t m);
    step_t s;
    s.ins = ins;
    s.rdy = rdy;
    s.eq  = eq;
    s.e   = e;
    s.m   = m;
    sq.push_back(s);
  endtask

  task automatic add_halt(input logic [15:0] ins, input logic be);
    obs_t e;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      e.halted = 1'b1;
      e.bus_error = be;
      push(ins, rnd1(), 1'b0, e, bmask());
    end
  endtask

  // Reference: one instruction as a list of expected cycles.
  // fst/mst = cycles memory withholds ready in fetch / mem.
  task automatic model_instr(input logic [15:0] ins, input logic eq,
                             input int fst, input int mst);
    obs_t e, m;
    logic [2:0] op;
    logic alu_op, memop, sw, rfb;
    op = ins[15:13];
    alu_op = (op <= 3'd3);
    memop = (op == 3'd4) || (op == 3'd5);
    sw = (op == 3'd4);
    rfb = (op == 3'd4) || (op == 3'd6);
    for (int i = 0; ; i++) begin
      if (i == TO) begin
        add_halt(ins, 1'b1);
        return;
      end
      e = '0;
      m = bmask();
      m.mem_we = 1'b1;
      m.mux_addr = 1'b1;
      e.mem_req = 1'b1;
      e.we_ir = (i == fst);
      push(ins, i == fst, eq, e, m);
      if (i == fst) break;
    end
    e = '0;
    m = bmask();
    m.mux_rf = 1'b1;
    e.mux_rf = rfb;
    push(ins, rnd1(), eq, e, m);
    if (op == 3'd7 && ins[6:0] != 7'd0) begin
      add_halt(ins, 1'b0);
      return;
    end
    e = '0;
    m = bmask();
    m.mux_rf = 1'b1;
    e.mux_rf = rfb;
    if (alu_op) begin
      m.func_alu = '1;
      m.mux_alu1 = 1'b1;
      m.mux_alu2 = 1'b1;
      m.mux_tgt = '1;
      m.mux_pc = '1;
      e.we_rf = 1'b1;
      e.mux_tgt = 2'b01;
      e.we_pc = 1'b1;
      e.mux_pc = 2'b00;
      e.func_alu = (op == 3'd2) ? 2'b01 :
                   (op == 3'd3) ? 2'b10 : 2'b00;
      e.mux_alu1 = (op == 3'd3);
      e.mux_alu2 = (op == 3'd1);
    end else if (op == 3'd6) begin
      m.mux_pc = '1;
      e.we_pc = 1'b1;
      e.mux_pc = eq ? 2'b01 : 2'b00;
    end else if (op == 3'd7) begin
      m.mux_tgt = '1;
      m.mux_pc = '1;
      e.we_rf = 1'b1;
      e.we_pc = 1'b1;
      e.mux_tgt = 2'b10;
      e.mux_pc = 2'b10;
    end else begin
      m.func_alu = '1;
      m.mux_alu1 = 1'b1;
      m.mux_alu2 = 1'b1;
      e.mux_alu2 = 1'b1;
    end
    push(ins, rnd1(), eq, e, m);
    if (!memop) return;
    for (int i = 0; ; i++) begin
      if (i == TO) begin
        add_halt(ins, 1'b1);
        return;
      end
      e = '0;
      m = bmask();
      m.mem_we = 1'b1;
      m.mux_addr = 1'b1;
      m.mux_rf = 1'b1;
      m.func_alu = '1;
      m.mux_alu1 = 1'b1;
      m.mux_alu2 = 1'b1;
      e.mem_req = 1'b1;
      e.mux_addr = 1'b1;
      e.mem_we = sw;
      e.mux_rf = sw;
      e.mux_alu2 = 1'b1;
      if (i == mst) begin
        e.we_pc = 1'b1;
        e.we_rf = !sw;
        m.mux_pc = '1;
        if (!sw) m.mux_tgt = '1;
      end
      push(ins, i == mst, eq, e, m);
      if (i == mst) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    alu_eq = 1'b1;
    instr = 16'h0503;
    @(negedge clk);
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", act, 18'h0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", act, 18'h0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    e = '0;
    e.mem_req = 1'b1;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL reset_fetch: got %h expected %h", act, e);
    end
  endtask

  task automatic test_alu();
    do_reset();
    model_instr(16'h0503, 1'b0, 0, 0);
    model_instr(16'h2505, 1'b0, 1, 0);
    model_instr(16'h4503, 1'b1, 0, 0);
    model_instr(16'h6abc, 1'b0, 2, 0);
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL alu step %0d instr %h: got %h expected %h",
                 i, sq[i].ins, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
  endtask

  task automatic test_lw_stall();
    do_reset();
    model_instr(16'ha505, 1'b0, 0, 3);
    model_instr(16'h8503, 1'b1, 1, 2);
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL lw_sw step %0d instr %h: got %h expected %h",
                 i, sq[i].ins, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
  endtask

  task automatic test_beq();
    do_reset();
    model_instr(16'hc57f, 1'b1, 0, 0);
    model_instr(16'hc57f, 1'b0, 0, 0);
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL beq step %0d eq %b: got %h expected %h",
                 i, sq[i].eq, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
  endtask

  task automatic test_jalr();
    do_reset();
    model_instr(16'hfc80, 1'b0, 0, 0);
    model_instr(16'hfc81, 1'b0, 0, 0);
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL jalr step %0d instr %h: got %h expected %h",
                 i, sq[i].ins, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
  endtask

  task automatic test_sw_timeout();
    do_reset();
    model_instr(16'h8500, 1'b0, 0, 100);
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL sw_timeout step %0d: got %h expected %h",
                 i, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL err_clear: got %h expected %h", act, 18'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    obs_t e;
    do_reset();
    instr = 16'ha505;
    alu_eq = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (!(mem_req === 1'b1 && MUX_addr === 1'b1)) begin
      errors++;
      $display("FAIL mid_mem_req: got req %b addr %b expected 1 1",
               mem_req, MUX_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL mid_mem_abort: got %h expected %h", act, 18'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e = '0;
    e.mem_req = 1'b1;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL mid_mem_restart: got %h expected %h", act, e);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] ins;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'd7) ins[6:0] = 7'd0;
      model_instr(ins, rnd1(), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)));
    end
    foreach (sq[i]) begin
      instr = sq[i].ins;
      mem_ready = sq[i].rdy;
      alu_eq = sq[i].eq;
      #1;
      checks++;
      if ((act & sq[i].m) !== (sq[i].e & sq[i].m)) begin
        errors++;
        $display("FAIL random step %0d instr %h: got %h expected %h",
                 i, sq[i].ins, act & sq[i].m, sq[i].e & sq[i].m);
      end
      @(negedge clk);
    end
    sq.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_stall();
    test_beq();
    test_jalr();
    test_sw_timeout();
    test_reset_mid_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
